// File: rtl/clock_enable_gen.sv
// Multi-channel NCO clock-enable generator with run-time rate updates.
// Define CLOCK_ENABLE_GEN_PHASE_ALIGN_EN to realign all channels on update.
module clock_enable_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int LOCK_CYCLES = 16,
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [ACC_WIDTH-1:0] cfg_step,
  output logic [CHANNELS-1:0]  outclk_en,
  output logic                 locked
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CHAN_W-1:0]      p_chan;
  logic [ACC_WIDTH-1:0]   p_step;
  logic [ACC_WIDTH-1:0]   step [CHANNELS];
  logic [ACC_WIDTH-1:0]   acc  [CHANNELS];
  logic [ACC_WIDTH:0]     sum  [CHANNELS];
  logic [CHANNELS-1:0]    clr;
  logic [CHANNELS-1:0]    sel;
  logic                   chan_ok;

  assign chan_ok = int'(p_chan) < CHANNELS;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, step[i]};
      sel[i] = (p_chan == CHAN_W'(i));
`ifdef CLOCK_ENABLE_GEN_PHASE_ALIGN_EN
      clr[i] = (state == APPLY) && chan_ok;
`else
      clr[i] = (state == APPLY) && chan_ok && sel[i];
`endif
    end
  end

  // Accumulators free-run; only cleared channels see an update edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      outclk_en <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        step[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clr[i]) begin
          acc[i]       <= '0;
          outclk_en[i] <= 1'b0;
          if (sel[i])
            step[i] <= p_step;
        end else begin
          acc[i]       <= sum[i][ACC_WIDTH-1:0];
          outclk_en[i] <= sum[i][ACC_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b1;
      p_chan    <= '0;
      p_step    <= '0;
    end else begin
      unique case (state)
        SETTLE, LOCKED: begin
          if (cfg_valid) begin
            state     <= APPLY;
            p_chan    <= cfg_chan;
            p_step    <= cfg_step;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end else if (state == SETTLE) begin
            if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        APPLY: begin
          state     <= SETTLE;
          cnt       <= '0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= SETTLE;
          cnt       <= '0;
          locked    <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen with a per-edge scoreboard.
// Three channels so a 2-bit cfg_chan can address an unused index.
module tb_clock_enable_gen;

  localparam int CH = 3;
  localparam int AW = 8;
  localparam int LC = 4;
`ifdef CLOCK_ENABLE_GEN_PHASE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [AW-1:0] cfg_step;
  logic [CH-1:0] outclk_en;
  logic          locked;

  clock_enable_gen #(
    .CHANNELS(CH),
    .ACC_WIDTH(AW),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_step(cfg_step),
    .outclk_en(outclk_en),
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [CH-1:0] en;
    logic          lk;
    logic          rdy;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_step [CH];
  logic [AW-1:0] m_acc  [CH];
  logic [CH-1:0] m_en;
  logic          pend;
  logic [1:0]    p_chan;
  logic [AW-1:0] p_step;
  int            pc [CH];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check_int(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    n_tests++;
    assert (outclk_en === e.en) else begin
      n_fail++;
      $error("FAIL %s en got %b want %b", tag, outclk_en, e.en);
    end
    n_tests++;
    assert (locked === e.lk) else begin
      n_fail++;
      $error("FAIL %s locked got %b want %b", tag, locked, e.lk);
    end
    n_tests++;
    assert (cfg_ready === e.rdy) else begin
      n_fail++;
      $error("FAIL %s ready got %b want %b", tag, cfg_ready, e.rdy);
    end
    for (int i = 0; i < CH; i++)
      if (outclk_en[i] === 1'b1) pc[i]++;
  endtask

  task automatic model_edge(input logic hs, input logic lk);
    logic [AW:0] s;
    logic        c;
    exp_t        e;
    for (int i = 0; i < CH; i++) begin
      c = pend && (int'(p_chan) < CH) && (ALIGN || int'(p_chan) == i);
      if (c) begin
        if (int'(p_chan) == i) m_step[i] = p_step;
        m_acc[i] = '0;
        m_en[i]  = 1'b0;
      end else begin
        s = {1'b0, m_acc[i]} + {1'b0, m_step[i]};
        m_acc[i] = s[AW-1:0];
        m_en[i]  = s[AW];
      end
    end
    pend   = hs;
    p_chan = cfg_chan;
    p_step = cfg_step;
    e.en  = m_en;
    e.lk  = lk;
    e.rdy = !hs;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [1:0] c,
                     input logic [AW-1:0] s, input logic lk,
                     input string tag);
    cfg_valid = v;
    cfg_chan  = c;
    cfg_step  = s;
    @(posedge refclk);
    model_edge(v, lk);
    #1;
    cfg_valid = 1'b0;
    check(tag);
  endtask

  task automatic idle(input int n, input logic lk, input string tag);
    repeat (n) cyc(1'b0, 2'd0, '0, lk, tag);
  endtask

  task automatic do_reset();
    exp_t e;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    @(posedge refclk);
    for (int i = 0; i < CH; i++) begin
      m_step[i] = '0;
      m_acc[i]  = '0;
    end
    m_en = '0;
    pend = 1'b0;
    e.en  = '0;
    e.lk  = 1'b0;
    e.rdy = 1'b1;
    sb.push_back(e);
    #1;
    check("reset");
    rst = 1'b0;
  endtask

  task automatic clr_pc();
    for (int i = 0; i < CH; i++) pc[i] = 0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_step  = '0;
    pend      = 1'b0;
    p_chan    = '0;
    p_step    = '0;
    m_en      = '0;
    clr_pc();
    #1;
    do_reset();
    idle(3, 1'b0, "settle");
    idle(1, 1'b1, "lock");
    idle(4, 1'b1, "locked_idle");
    check_int("no_pulse_step0", pc[0] + pc[1] + pc[2], 0);

    clr_pc();
    cyc(1'b1, 2'd0, 8'h40, 1'b0, "hs_ch0");
    idle(4, 1'b0, "apply_ch0");
    check_int("ch0_no_early", pc[0], 0);
    idle(1, 1'b1, "relock_ch0");
    check_int("ch0_first", pc[0], 1);
    clr_pc();
    idle(16, 1'b1, "run_ch0");
    check_int("ch0_rate", pc[0], 4);

    cyc(1'b1, 2'd1, 8'h60, 1'b0, "hs_ch1");
    idle(4, 1'b0, "apply_ch1");
    idle(1, 1'b1, "relock_ch1");
    clr_pc();
    idle(8, 1'b1, "run_ch1");
    check_int("ch1_rate", pc[1], 3);
    check_int("ch0_rate2", pc[0], 2);

    cyc(1'b1, 2'd1, 8'h20, 1'b0, "hs_a");
    idle(2, 1'b0, "settle_a");
    cyc(1'b1, 2'd0, 8'h40, 1'b0, "hs_b");
    idle(4, 1'b0, "resettle_b");
    idle(1, 1'b1, "relock_b");
    idle(8, 1'b1, "run_b");

    cyc(1'b1, 2'd3, 8'h80, 1'b0, "hs_oob");
    idle(4, 1'b0, "apply_oob");
    idle(1, 1'b1, "relock_oob");
    clr_pc();
    idle(16, 1'b1, "run_oob");
    check_int("oob_ch2_idle", pc[2], 0);
    check_int("oob_ch1_rate", pc[1], 2);

    cyc(1'b1, 2'd0, 8'h80, 1'b0, "hs_80");
    idle(4, 1'b0, "apply_80");
    idle(1, 1'b1, "relock_80");
    clr_pc();
    idle(4, 1'b1, "run_80");
    check_int("ch0_half", pc[0], 2);
    cyc(1'b1, 2'd1, 8'h10, 1'b0, "hs_pend");
    do_reset();
    clr_pc();
    idle(3, 1'b0, "settle_rst");
    idle(1, 1'b1, "lock_rst");
    idle(8, 1'b1, "post_rst");
    check_int("post_rst_quiet", pc[0] + pc[1] + pc[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
